// File: rtl/counter_snapshot_sequencer_if.sv
// Host-side readout bus of the counter snapshot sequencer.
//   data_out    word being presented
//   data_index  counter index of data_out
//   data_valid  data_out/data_index are valid
//   data_ack    host consumes the word when high together with data_valid
// master: the sequencer (drives the word), slave: the host (drives ack).
interface counter_snapshot_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 2
);
    logic [WIDTH-1:0] data_out;
    logic [IDX_W-1:0] data_index;
    logic             data_valid;
    logic             data_ack;

    modport master (
        output data_out, data_index, data_valid,
        input  data_ack
    );

    modport slave (
        input  data_out, data_index, data_valid,
        output data_ack
    );
endinterface

// File: rtl/counter_snapshot_sequencer.sv
// Coherent snapshot and sequenced readout of NB_COUNTERS quadrature counters.
// A start request in IDLE captures every counter on the same edge. The block
// then presents one word per counter, in index order, over a valid/ack
// handshake. Each word is either the raw count or the wrapped delta since the
// previous snapshot.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   count_in    concatenated counters, counter 0 in the LSBs
//   start       snapshot request
//   delta_mode  word format latched with an accepted start (1 = delta)
//   busy        transfer in progress
//   overrun     sticky: start was seen while busy; cleared by an accepted start
//   bus         readout handshake (data_out/data_index/data_valid/data_ack)

// One counter lane: snapshot register, previous snapshot, word formatter.
module counter_snapshot_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic             delta,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] word
);
    logic [WIDTH-1:0] snap;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
            prev <= '0;
        end else if (capture) begin
            snap <= count;
            prev <= snap;
        end
    end

    // Modular subtraction gives the signed movement in two's complement,
    // correct across counter wrap as long as it moved < 2^(WIDTH-1).
    assign word = delta ? (snap - prev) : snap;
endmodule

module counter_snapshot_sequencer #(
    parameter int NB_COUNTERS = 4,
    parameter int WIDTH       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NB_COUNTERS*WIDTH-1:0] count_in,
    input  logic                         start,
    input  logic                         delta_mode,
    output logic                         busy,
    output logic                         overrun,
    counter_snapshot_sequencer_if.master bus
);
    localparam int IDX_W = (NB_COUNTERS > 1) ? $clog2(NB_COUNTERS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NB_COUNTERS - 1);

    typedef enum logic [0:0] {IDLE, PRESENT} state_t;

    state_t                              state, state_nx;
    logic [IDX_W-1:0]                    idx, idx_nx;
    logic                                capture;
    logic                                last_ld;
    logic                                final_ack;
    logic                                overrun_nx;
    logic                                mode;
    logic [WIDTH-1:0]                    last_word;
    logic [NB_COUNTERS-1:0][WIDTH-1:0]   cnt;
    logic [NB_COUNTERS-1:0][WIDTH-1:0]   words;

    assign cnt = count_in;

    // All lanes share one capture strobe, so the snapshot is coherent.
    for (genvar i = 0; i < NB_COUNTERS; i++) begin : g_lane
        counter_snapshot_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .capture (capture),
            .delta   (mode),
            .count   (cnt[i]),
            .word    (words[i])
        );
    end

    assign final_ack = (state == PRESENT) && bus.data_ack && (idx == LAST);

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        capture    = 1'b0;
        last_ld    = 1'b0;
        overrun_nx = overrun;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_nx   = PRESENT;
                    idx_nx     = '0;
                    overrun_nx = 1'b0;
                end
            end
            PRESENT: begin
                if (bus.data_ack) begin
                    if (idx == LAST) begin
                        last_ld  = 1'b1;
                        state_nx = IDLE;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
                // A start coinciding with the final ack is treated as an idle
                // start so back-to-back snapshots lose no cycle.
                if (start) begin
                    if (final_ack) begin
                        capture    = 1'b1;
                        state_nx   = PRESENT;
                        idx_nx     = '0;
                        overrun_nx = 1'b0;
                    end else begin
                        overrun_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            mode      <= 1'b0;
            overrun   <= 1'b0;
            last_word <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            overrun <= overrun_nx;
            if (capture) mode      <= delta_mode;
            if (last_ld) last_word <= words[LAST];
        end
    end

    // Outside a transfer the bus keeps showing the last word delivered.
    assign busy           = (state == PRESENT);
    assign bus.data_valid = busy;
    assign bus.data_index = idx;
    assign bus.data_out   = busy ? words[idx] : last_word;
endmodule

// File: tb/tb_counter_snapshot_sequencer.sv
// Testbench for counter_snapshot_sequencer (NB_COUNTERS=4, WIDTH=8).
// A reference model pushes the expected words into a queue on each capture
// edge; a negedge monitor pops and compares every word the host consumes and
// tracks busy/valid/overrun. Scenario tasks add their own directed checks.
module tb_counter_snapshot_sequencer;
    localparam int NB = 4;
    localparam int W  = 8;

    typedef struct {
        bit [1:0] idx;
        bit [7:0] word;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          delta_mode = 1'b0;
    logic          ack = 1'b0;
    logic [31:0]   count_in = '0;
    logic          busy;
    logic          overrun;

    int n_checks = 0;
    int n_fail   = 0;

    bit       m_busy = 1'b0;
    bit       m_over = 1'b0;
    bit [1:0] m_idx  = '0;
    bit [7:0] m_snap [NB];
    exp_t     exp_q [$];

    counter_snapshot_sequencer_if #(.WIDTH(W), .IDX_W(2)) bus ();
    assign bus.data_ack = ack;

    counter_snapshot_sequencer #(.NB_COUNTERS(NB), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .start      (start),
        .delta_mode (delta_mode),
        .busy       (busy),
        .overrun    (overrun),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Reference model: sampled on the same edge the DUT captures on.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_idx  <= '0;
            m_over <= 1'b0;
            for (int i = 0; i < NB; i++) m_snap[i] <= '0;
            exp_q.delete();
        end else begin
            if (m_busy && ack) begin
                if (m_idx == 2'd3) begin
                    m_busy <= 1'b0;
                    m_idx  <= '0;
                end else begin
                    m_idx <= m_idx + 2'd1;
                end
            end
            if (start && (!m_busy || (ack && m_idx == 2'd3))) begin
                for (int i = 0; i < NB; i++) begin
                    exp_q.push_back('{2'(i), delta_mode ? 8'(count_in[i*8 +: 8] - m_snap[i])
                                                       : count_in[i*8 +: 8]});
                    m_snap[i] <= count_in[i*8 +: 8];
                end
                m_busy <= 1'b1;
                m_idx  <= '0;
                m_over <= 1'b0;
            end else if (start && m_busy) begin
                m_over <= 1'b1;
            end
        end
    end

    // Monitor: every consumed word is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (busy !== m_busy || bus.data_valid !== m_busy) begin
                n_fail++;
                $display("FAIL mon_busy: busy=%b valid=%b expected %b", busy, bus.data_valid, m_busy);
            end
            n_checks++;
            if (overrun !== m_over) begin
                n_fail++;
                $display("FAIL mon_overrun: got %b expected %b", overrun, m_over);
            end
            if (bus.data_valid === 1'b1 && ack) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_word: unexpected word %h idx %0d", bus.data_out, bus.data_index);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.data_out !== e.word || bus.data_index !== e.idx) begin
                        n_fail++;
                        $display("FAIL mon_word: got %h idx %0d expected %h idx %0d",
                                 bus.data_out, bus.data_index, e.word, e.idx);
                    end
                end
            end
        end
    end

    // One-cycle start pulse; returns 1 ns after the capture edge.
    task automatic start_pulse(input logic [31:0] cnt, input logic mode);
        @(posedge clk); #1;
        count_in   = cnt;
        delta_mode = mode;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; ack = 1'b1; count_in = $urandom;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.data_out !== 8'h00 || bus.data_index !== 2'd0 || bus.data_valid !== 1'b0 ||
            busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: out=%h idx=%0d valid=%b busy=%b ovr=%b expected all 0",
                     bus.data_out, bus.data_index, bus.data_valid, busy, overrun);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.data_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: valid=%b busy=%b expected 0", bus.data_valid, busy);
        end
    endtask

    task automatic test_raw();
        logic [7:0] tbl [4];
        tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
        ack = 1'b1;
        start_pulse(32'h44332211, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.data_valid !== 1'b1 || bus.data_index !== 2'(k) || bus.data_out !== tbl[k]) begin
                n_fail++;
                $display("FAIL raw_word%0d: valid=%b idx=%0d out=%h expected 1 %0d %h",
                         k, bus.data_valid, bus.data_index, bus.data_out, k, tbl[k]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== 8'h44 || bus.data_index !== 2'd0) begin
            n_fail++;
            $display("FAIL raw_end: busy=%b valid=%b out=%h idx=%0d expected 0 0 44 0",
                     busy, bus.data_valid, bus.data_out, bus.data_index);
        end
    endtask

    task automatic test_delta_wrap();
        ack = 1'b1;
        start_pulse(32'h101010FE, 1'b0);
        wait_idle();
        start_pulse(32'h10121003, 1'b1);
        n_checks++;
        if (bus.data_out !== 8'h05) begin
            n_fail++;
            $display("FAIL delta_wrap_up: got %h expected 05", bus.data_out);
        end
        wait_idle();
        start_pulse(32'h0F1210FE, 1'b1);
        n_checks++;
        if (bus.data_out !== 8'hFB) begin
            n_fail++;
            $display("FAIL delta_wrap_down: got %h expected fb", bus.data_out);
        end
        wait_idle();
    endtask

    task automatic test_stall();
        ack = 1'b0;
        start_pulse(32'hA4A3A2A1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            count_in = $urandom;
            start    = (k == 4);
            n_checks++;
            if (bus.data_out !== 8'hA1 || bus.data_index !== 2'd0 || bus.data_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: out=%h idx=%0d valid=%b expected a1 0 1",
                         k, bus.data_out, bus.data_index, bus.data_valid);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_overrun: ovr=%b busy=%b expected 1 1", overrun, busy);
        end
        ack = 1'b1;
        wait_idle();
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b expected 1", overrun);
        end
        start_pulse(32'h01020304, 1'b0);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b expected 0", overrun);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        ack = 1'b1;
        start_pulse(32'h55667788, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.data_index !== 2'd3) begin
            n_fail++;
            $display("FAIL b2b_last_idx: got %0d expected 3", bus.data_index);
        end
        count_in = 32'hDDCCBBAA;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.data_index !== 2'd0 || busy !== 1'b1 ||
            overrun !== 1'b0 || bus.data_out !== 8'hAA) begin
            n_fail++;
            $display("FAIL b2b_restart: valid=%b idx=%0d busy=%b ovr=%b out=%h expected 1 0 1 0 aa",
                     bus.data_valid, bus.data_index, busy, overrun, bus.data_out);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        ack = 1'b1;
        start_pulse(32'h99887766, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.data_index !== 2'd2) begin
            n_fail++;
            $display("FAIL rstmid_idx: got %0d expected 2", bus.data_index);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (bus.data_out !== 8'h00 || bus.data_index !== 2'd0 || bus.data_valid !== 1'b0 ||
            busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: out=%h idx=%0d valid=%b busy=%b ovr=%b expected all 0",
                     bus.data_out, bus.data_index, bus.data_valid, busy, overrun);
        end
        start_pulse(32'h0A0B0C3D, 1'b1);
        n_checks++;
        if (bus.data_out !== 8'h3D) begin
            n_fail++;
            $display("FAIL rstmid_delta_from_zero: got %h expected 3d", bus.data_out);
        end
        wait_idle();
    endtask

    // Quadrature-style counters: each step holds, increments or decrements.
    task automatic test_random();
        logic [7:0] ctr [NB];
        for (int i = 0; i < NB; i++) ctr[i] = 8'($urandom);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NB; i++) begin
                case ($urandom_range(0, 2))
                    1: ctr[i] = ctr[i] + 8'd1;
                    2: ctr[i] = ctr[i] - 8'd1;
                    default: ;
                endcase
                count_in[i*8 +: 8] = ctr[i];
            end
            start      = ($urandom_range(0, 5) == 0);
            delta_mode = 1'($urandom);
            ack        = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        ack   = 1'b1;
        wait_idle();
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: %0d words left, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_delta_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
